// File: rtl/motor_drive.sv
// Two-wheel H-bridge drive: maps a registered steering command to slew-limited
// PWM duty and direction per wheel, with a zero-speed dead time before any reversal.
module motor_drive #(
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned RAMP_DIV    = 1000,
   parameter int unsigned DEAD_TICKS  = 50,
   parameter int unsigned DUTY_FAST   = 255,
   parameter int unsigned DUTY_NORMAL = 192,
   parameter int unsigned DUTY_SLOW   = 96
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] drive_command,
   output logic       left_pwm,
   output logic       left_dir,
   output logic       right_pwm,
   output logic       right_dir,
   output logic       moving,
   output logic       cmd_invalid
);

   localparam int unsigned PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int unsigned DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
   localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(RAMP_DIV - 1);
   localparam logic [DEAD_W-1:0]   DEAD_LAST = DEAD_W'(DEAD_TICKS - 1);
   localparam logic [PWM_BITS-1:0] D_FAST    = PWM_BITS'(DUTY_FAST);
   localparam logic [PWM_BITS-1:0] D_NORMAL  = PWM_BITS'(DUTY_NORMAL);
   localparam logic [PWM_BITS-1:0] D_SLOW    = PWM_BITS'(DUTY_SLOW);

   typedef enum logic {RUN, DEAD} wheel_state_t;

   // Wheel index 0 is left, 1 is right.
   logic [2:0]          cmd_q;
   logic [PRE_W-1:0]    pre;
   logic                ramp_tick;
   logic [PWM_BITS-1:0] cnt;
   logic [1:0]          dir;
   logic [1:0]          tgt_dir;
   logic [PWM_BITS-1:0] tgt_duty [2];
   logic [PWM_BITS-1:0] goal     [2];
   logic [PWM_BITS-1:0] duty     [2];
   logic [PWM_BITS-1:0] duty_q   [2];
   logic [DEAD_W-1:0]   dead_cnt [2];
   wheel_state_t        state    [2];

   assign ramp_tick = (pre == PRE_LAST);

   always_comb begin
      tgt_dir     = dir;
      tgt_duty[0] = '0;
      tgt_duty[1] = '0;
      case (cmd_q)
         3'd1: begin tgt_dir = 2'b01; tgt_duty[0] = D_FAST;   tgt_duty[1] = D_FAST;   end
         3'd2: begin tgt_dir = 2'b00; tgt_duty[0] = D_SLOW;   tgt_duty[1] = D_NORMAL; end
         3'd3: begin tgt_dir = 2'b00; tgt_duty[0] = D_NORMAL; tgt_duty[1] = D_NORMAL; end
         3'd4: begin tgt_dir = 2'b00; tgt_duty[0] = D_NORMAL; tgt_duty[1] = D_SLOW;   end
         3'd5: begin tgt_dir = 2'b10; tgt_duty[0] = D_FAST;   tgt_duty[1] = D_FAST;   end
         default: ;
      endcase
      for (int unsigned w = 0; w < 2; w++) begin
         goal[w] = (tgt_dir[w] == dir[w]) ? tgt_duty[w] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_q  <= '0;
         pre    <= '0;
         cnt    <= '0;
         dir    <= '0;
         moving <= 1'b0;
         for (int unsigned w = 0; w < 2; w++) begin
            duty[w]     <= '0;
            duty_q[w]   <= '0;
            dead_cnt[w] <= '0;
            state[w]    <= RUN;
         end
      end else begin
         cmd_q  <= drive_command;
         pre    <= ramp_tick ? '0 : pre + 1'b1;
         cnt    <= cnt + 1'b1;
         moving <= (duty_q[0] != '0) || (duty_q[1] != '0);
         for (int unsigned w = 0; w < 2; w++) begin
            if (&cnt) duty_q[w] <= duty[w];
            if (ramp_tick) begin
               if (state[w] == RUN) begin
                  if ((duty[w] == '0) && (tgt_dir[w] != dir[w]) && (tgt_duty[w] != '0)) begin
                     state[w]    <= DEAD;
                     dead_cnt[w] <= '0;
                  end else if (duty[w] < goal[w]) begin
                     duty[w] <= duty[w] + 1'b1;
                  end else if (duty[w] > goal[w]) begin
                     duty[w] <= duty[w] - 1'b1;
                  end
               end else if (dead_cnt[w] == DEAD_LAST) begin
                  // Exit also waits for the applied duty to be zero, so dir never
                  // flips while a stale nonzero duty_q could drive the bridge.
                  if (duty_q[w] == '0) begin
                     dir[w]   <= tgt_dir[w];
                     state[w] <= RUN;
                  end
               end else begin
                  dead_cnt[w] <= dead_cnt[w] + 1'b1;
               end
            end
         end
      end
   end

   assign left_pwm    = (state[0] == RUN) && (cnt < duty_q[0]);
   assign right_pwm   = (state[1] == RUN) && (cnt < duty_q[1]);
   assign left_dir    = dir[0];
   assign right_dir   = dir[1];
   assign cmd_invalid = cmd_q[2] & cmd_q[1];

endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive with small parameters (16-clock PWM period,
// ramp tick every 2 clocks, 3-tick dead time); edges counted from reset release.
module tb_motor_drive;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] drive_command = 3'd0;
   logic       left_pwm, left_dir, right_pwm, right_dir, moving, cmd_invalid;

   int checks = 0;
   int errors = 0;
   int lh, rh;

   always #5 clk = ~clk;

   motor_drive #(
      .PWM_BITS(4), .RAMP_DIV(2), .DEAD_TICKS(3),
      .DUTY_FAST(15), .DUTY_NORMAL(12), .DUTY_SLOW(6)
   ) dut (
      .clk(clk), .reset(reset), .drive_command(drive_command),
      .left_pwm(left_pwm), .left_dir(left_dir),
      .right_pwm(right_pwm), .right_dir(right_dir),
      .moving(moving), .cmd_invalid(cmd_invalid)
   );

   function automatic logic [5:0] outs();
      return {left_pwm, left_dir, right_pwm, right_dir, moving, cmd_invalid};
   endfunction

   // From a negedge: pass n rising edges, land on the following negedge.
   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Leaves reset just released at a negedge; the next rising edge is edge 1.
   task automatic apply_reset(input logic [2:0] cmd);
      reset = 1'b1;
      drive_command = cmd;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   // Counts high samples over one 16-clock PWM period.
   task automatic measure(output int l, output int r);
      l = 0;
      r = 0;
      for (int i = 0; i < 16; i++) begin
         if (left_pwm === 1'b1) l++;
         if (right_pwm === 1'b1) r++;
         wait_edges(1);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_command = 3'd7;
      repeat (2) @(negedge clk);
      checks++; if (outs() !== 6'b000000) begin errors++; $display("FAIL reset_outs: got %b expected 000000", outs()); end
   endtask

   task automatic test_straight_ramp();
      apply_reset(3'd3);
      wait_edges(15);
      checks++; if (outs() !== 6'b000000) begin errors++; $display("FAIL straight_pre_latch: got %b expected 000000", outs()); end
      wait_edges(1);
      checks++; if (moving !== 1'b0) begin errors++; $display("FAIL straight_moving_e16: got %b expected 0", moving); end
      measure(lh, rh);
      checks++; if (lh !== 7 || rh !== 7) begin errors++; $display("FAIL straight_p1: got %0d/%0d expected 7/7", lh, rh); end
      checks++; if (moving !== 1'b1) begin errors++; $display("FAIL straight_moving_rise: got %b expected 1", moving); end
      measure(lh, rh);
      checks++; if (lh !== 12 || rh !== 12) begin errors++; $display("FAIL straight_p2: got %0d/%0d expected 12/12", lh, rh); end
      measure(lh, rh);
      checks++; if (lh !== 12 || rh !== 12) begin errors++; $display("FAIL straight_p3: got %0d/%0d expected 12/12", lh, rh); end
      checks++; if ({left_dir, right_dir, cmd_invalid} !== 3'b000) begin errors++; $display("FAIL straight_dirs: got %b expected 000", {left_dir, right_dir, cmd_invalid}); end
   endtask

   task automatic test_gentle_turn();
      apply_reset(3'd3);
      wait_edges(48);
      drive_command = 3'd2;
      measure(lh, rh);
      checks++; if (lh !== 12 || rh !== 12) begin errors++; $display("FAIL left_turn_p0: got %0d/%0d expected 12/12", lh, rh); end
      measure(lh, rh);
      checks++; if (lh !== 6 || rh !== 12) begin errors++; $display("FAIL left_turn_p1: got %0d/%0d expected 6/12", lh, rh); end
      drive_command = 3'd4;
      measure(lh, rh);
      checks++; if (lh !== 6 || rh !== 12) begin errors++; $display("FAIL right_turn_p0: got %0d/%0d expected 6/12", lh, rh); end
      measure(lh, rh);
      checks++; if (lh !== 12 || rh !== 6) begin errors++; $display("FAIL right_turn_p1: got %0d/%0d expected 12/6", lh, rh); end
      checks++; if ({left_dir, right_dir} !== 2'b00) begin errors++; $display("FAIL turn_dirs: got %b expected 00", {left_dir, right_dir}); end
   endtask

   task automatic test_fast_left();
      logic exp_dir;
      apply_reset(3'd3);
      wait_edges(36);
      drive_command = 3'd1;
      wait_edges(12);
      measure(lh, rh);
      checks++; if (lh !== 7 || rh !== 15) begin errors++; $display("FAIL fast_left_down: got %0d/%0d expected 7/15", lh, rh); end
      lh = 0;
      for (int i = 0; i < 16; i++) begin
         exp_dir = (64 + i >= 68);
         checks++; if (left_dir !== exp_dir) begin errors++; $display("FAIL fast_left_dir_e%0d: got %b expected %b", 64 + i, left_dir, exp_dir); end
         if (left_pwm === 1'b1) lh++;
         wait_edges(1);
      end
      checks++; if (lh !== 0) begin errors++; $display("FAIL fast_left_dead_low: got %0d expected 0", lh); end
      measure(lh, rh);
      checks++; if (lh !== 5 || rh !== 15) begin errors++; $display("FAIL fast_left_up1: got %0d/%0d expected 5/15", lh, rh); end
      measure(lh, rh);
      checks++; if (lh !== 13 || rh !== 15) begin errors++; $display("FAIL fast_left_up2: got %0d/%0d expected 13/15", lh, rh); end
      measure(lh, rh);
      checks++; if (lh !== 15 || rh !== 15) begin errors++; $display("FAIL fast_left_full: got %0d/%0d expected 15/15", lh, rh); end
      checks++; if ({left_dir, right_dir} !== 2'b10) begin errors++; $display("FAIL fast_left_dirs: got %b expected 10", {left_dir, right_dir}); end
   endtask

   task automatic test_fast_right();
      apply_reset(3'd3);
      wait_edges(36);
      drive_command = 3'd5;
      wait_edges(31);
      checks++; if ({left_dir, right_dir} !== 2'b00) begin errors++; $display("FAIL fast_right_dirs_e67: got %b expected 00", {left_dir, right_dir}); end
      wait_edges(1);
      checks++; if ({left_dir, right_dir} !== 2'b01) begin errors++; $display("FAIL fast_right_dirs_e68: got %b expected 01", {left_dir, right_dir}); end
      wait_edges(28);
      measure(lh, rh);
      checks++; if (lh !== 15 || rh !== 13) begin errors++; $display("FAIL fast_right_up: got %0d/%0d expected 15/13", lh, rh); end
   endtask

   task automatic test_dead_cancel();
      int bad;
      apply_reset(3'd3);
      wait_edges(36);
      drive_command = 3'd1;
      wait_edges(27);
      drive_command = 3'd3;
      wait_edges(1);
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (left_dir !== 1'b0 || left_pwm !== 1'b0) bad++;
         wait_edges(1);
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL dead_cancel_hold: got %0d bad samples expected 0", bad); end
      measure(lh, rh);
      checks++; if (lh !== 5 || rh !== 12) begin errors++; $display("FAIL dead_cancel_up: got %0d/%0d expected 5/12", lh, rh); end
      measure(lh, rh);
      checks++; if (lh !== 12 || rh !== 12) begin errors++; $display("FAIL dead_cancel_full: got %0d/%0d expected 12/12", lh, rh); end
      checks++; if ({left_dir, right_dir} !== 2'b00) begin errors++; $display("FAIL dead_cancel_dirs: got %b expected 00", {left_dir, right_dir}); end
   endtask

   task automatic test_invalid();
      apply_reset(3'd3);
      wait_edges(47);
      checks++; if (cmd_invalid !== 1'b0) begin errors++; $display("FAIL invalid_before: got %b expected 0", cmd_invalid); end
      drive_command = 3'd7;
      wait_edges(1);
      checks++; if (cmd_invalid !== 1'b1) begin errors++; $display("FAIL invalid_7: got %b expected 1", cmd_invalid); end
      measure(lh, rh);
      checks++; if (lh !== 12 || rh !== 12) begin errors++; $display("FAIL invalid_p0: got %0d/%0d expected 12/12", lh, rh); end
      measure(lh, rh);
      checks++; if (lh !== 5 || rh !== 5) begin errors++; $display("FAIL invalid_p1: got %0d/%0d expected 5/5", lh, rh); end
      checks++; if (outs() !== 6'b000011) begin errors++; $display("FAIL invalid_e80: got %b expected 000011", outs()); end
      wait_edges(1);
      checks++; if (outs() !== 6'b000001) begin errors++; $display("FAIL invalid_moving_fall: got %b expected 000001", outs()); end
      drive_command = 3'd0;
      wait_edges(1);
      checks++; if (cmd_invalid !== 1'b0) begin errors++; $display("FAIL invalid_stop: got %b expected 0", cmd_invalid); end
      drive_command = 3'd6;
      wait_edges(1);
      checks++; if (cmd_invalid !== 1'b1) begin errors++; $display("FAIL invalid_6: got %b expected 1", cmd_invalid); end
   endtask

   task automatic test_reset_mid_ramp();
      apply_reset(3'd3);
      wait_edges(36);
      drive_command = 3'd1;
      wait_edges(42);
      checks++; if (outs() !== 6'b011010) begin errors++; $display("FAIL midramp_before: got %b expected 011010", outs()); end
      reset = 1'b1;
      wait_edges(1);
      checks++; if (outs() !== 6'b000000) begin errors++; $display("FAIL midramp_reset: got %b expected 000000", outs()); end
      apply_reset(3'd3);
      wait_edges(16);
      measure(lh, rh);
      checks++; if (lh !== 7 || rh !== 7) begin errors++; $display("FAIL midramp_restart: got %0d/%0d expected 7/7", lh, rh); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_straight_ramp();
      test_gentle_turn();
      test_fast_left();
      test_fast_right();
      test_dead_cancel();
      test_invalid();
      test_reset_mid_ramp();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/motor_drive.md
Name: motor_drive

Overview:
Consumes the 3-bit drive_command produced by the steering/audio decision logic and turns it into two independent H-bridge motor signals (PWM + direction) for the left and right wheels.
- Duty is slew-rate limited so speed changes ramp rather than step.
- A wheel being asked to reverse first ramps to zero, then idles for a dead time before its direction flips.
- Sits between the drive decision logic and the motor driver pins.

Parameters:
PWM_BITS, 8, PWM counter width; PWM period = 2^PWM_BITS clocks.
RAMP_DIV, 1000, clocks per ramp tick; duty moves at most 1 LSB per tick.
DEAD_TICKS, 50, ramp ticks a wheel holds PWM low at zero speed before a direction flip.
DUTY_FAST, 255, duty for spin-turn wheels (Fast_left/Fast_right).
DUTY_NORMAL, 192, duty for straight-line and outer-wheel motion.
DUTY_SLOW, 96, duty for the inner wheel on gentle turns.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
drive_command  input  3  0 Stop, 1 Fast_left, 2 Left, 3 Straight, 4 Right, 5 Fast_right; 6/7 invalid
left_pwm  output  1  left motor PWM
left_dir  output  1  left motor direction, 0 forward, 1 reverse
right_pwm  output  1  right motor PWM
right_dir  output  1  right motor direction, 0 forward, 1 reverse
moving  output  1  high when either applied duty is nonzero
cmd_invalid  output  1  high while registered command is 6 or 7

Behaviour:
Reset:
- Synchronous, active-high: PWM counter, prescaler, duties, dead counters all 0.
- Both dirs 0; both FSMs RUN.
- All outputs 0.

Command register:
- drive_command is registered every clk into cmd_q; targets derive from cmd_q, giving 1 cycle latency.
- 6/7 are treated as Stop and set cmd_invalid.

Targets per cmd_q (L dir/duty, R dir/duty):
- 0: duty 0 / 0; target dir equals current dir.
- 1: L rev FAST, R fwd FAST.
- 2: L fwd SLOW, R fwd NORMAL.
- 3: both fwd NORMAL.
- 4: L fwd NORMAL, R fwd SLOW.
- 5: L fwd FAST, R rev FAST.

Prescaler:
- Counts 0..RAMP_DIV-1.
- ramp_tick pulses one clk when it wraps to 0.
- Shared by both wheels.

Per-wheel FSM (identical, independent):
- RUN, on ramp_tick:
  - goal = target duty if target dir == dir, else 0.
  - duty steps ±1 toward goal and saturates at goal.
  - If duty == 0 and target dir != dir and target duty != 0: go to DEAD and clear dead_cnt.
- DEAD:
  - PWM forced low and duty held 0.
  - dead_cnt increments on each ramp_tick.
  - When dead_cnt reaches DEAD_TICKS-1 on a tick: dir <= current target dir, then return to RUN. Ramp-up starts on the next tick.
  - If the target changes to Stop or back to the same dir during DEAD, DEAD still completes; dir then equals the target, so no flip occurs.
- dir never changes in RUN. It changes only when leaving DEAD.

PWM generation:
- Counter is free-running 0..2^PWM_BITS-1 and wraps.
- Applied duty (duty_q) is latched from the FSM duty only when the counter == max, so no mid-period glitches.
- pwm = (counter < duty_q).
- Duty 0 gives a constantly low output; maximum duty gives high for 2^PWM_BITS-1 of 2^PWM_BITS clocks.
- The dir output changes only while that wheel's duty_q == 0.

moving: OR of (left duty_q != 0) and (right duty_q != 0), registered.

Simultaneous events:
- A command change on the same clk as a ramp_tick is applied on the next tick, because targets come from cmd_q.
- reset dominates everything.
- A reset asserted mid-ramp or mid-DEAD returns the block to the reset state on the next clk.

Test Plan:
- Params PWM_BITS=4, RAMP_DIV=2, DEAD_TICKS=3, FAST=15, NORMAL=12, SLOW=6, for all scenarios below.
- Reset, drive_command=3 → duties ramp 0→12 one step per 2 clks and saturate at 12. Each period then shows 12 high / 4 low on both pwm. Both dirs stay 0. moving rises at the first period boundary with duty ≥1.
- Steady Straight, then drive_command=2 → left ramps 12→6 over 6 ticks, right stays 12. Dirs are unchanged throughout.
- Steady Straight, then drive_command=1 → left ramps 12→0 and holds 3 ticks low with left_dir=0, then left_dir=1 and left ramps 0→15. Right ramps 12→15 meanwhile and never reverses.
- During left DEAD, switch drive_command to 3 → DEAD completes, left_dir stays 0, then left ramps to 12. No reverse pulse ever appears on left_pwm.
- drive_command=7 from steady Straight → cmd_invalid=1 after 1 clk and both duties ramp to 0. moving falls at the period boundary after both duty_q reach 0.
- Assert reset mid-ramp at duty=5 → next clk all outputs 0. After reset release, ramp restarts from 0.
